// File: rtl/simplebus_mem_follower_if.sv
// simplebus_mem_follower_if
// Shared 8-bit multiplexed simplebus as seen by one follower.
// Tri-state resolution happens outside the follower: it reports what it
// wants to drive (data_out/dv_out) and whether it drives (data_oe/dv_oe).
//   start    : leader start strobe, valid in the upper-address cycle
//   read     : 1=read, 0=write, valid in the low-address cycle
//   address  : multiplexed address byte
//   data_in  : bus data as seen by the follower
//   data_out : read data offered to the bus, qualified by data_oe
//   dv_in    : bus dataValid as seen by the follower
//   dv_out   : dataValid offered to the bus, qualified by dv_oe
// Modports: master (leader / bench side), slave (follower side).
interface simplebus_mem_follower_if;
    logic       start;
    logic       read;
    logic [7:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       dv_in;
    logic       dv_out;
    logic       dv_oe;

    modport master (
        output start, read, address, data_in, dv_in,
        input  data_out, data_oe, dv_out, dv_oe
    );

    modport slave (
        input  start, read, address, data_in, dv_in,
        output data_out, data_oe, dv_out, dv_oe
    );
endinterface

// File: rtl/simplebus_mem_follower.sv
// simplebus_mem_follower
// Memory follower on the shared simplebus. A transaction is a start pulse
// with the upper address byte, then the mid and low bytes. Only when the
// upper byte equals DEV_ID does the follower take part: a read drives data
// after READ_LATENCY cycles, a write waits for dv_in and stores data_in.
// The local memory is 2^MEM_AW bytes, indexed by the low MEM_AW address bits.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; returns the FSM to IDLE and releases the bus
//   bus   : simplebus_mem_follower_if.slave
// Optional build macro: SIMPLEBUS_MEM_INIT_EN - memory initialises to DEV_ID.
module simplebus_mem_follower #(
    parameter logic [7:0] DEV_ID       = 8'h00,
    parameter int         MEM_AW       = 16,
    parameter int         READ_LATENCY = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    simplebus_mem_follower_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, ADDR_MID, ADDR_LO, READ, WRITE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY - 1);

    state_t      state;
    state_t      next_state;
    logic [23:0] addr;
    logic [3:0]  wait_cnt;
    logic [7:0]  rd_data;
    logic [15:0] lo_word;
    logic [MEM_AW-1:0] mem_idx;

    logic [7:0] mem [2**MEM_AW];

`ifdef SIMPLEBUS_MEM_INIT_EN
    // Power-up contents for FPGA init / simulation; reset does not touch these.
    initial begin
        for (int i = 0; i < 2**MEM_AW; i++) begin
            mem[i] = DEV_ID;
        end
    end
`else
    // Memory contents are undefined until written.
`endif

    // State register and READ wait counter. The counter is cleared on the
    // way into READ so it counts cycles spent in READ from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (state == ADDR_LO) begin
                wait_cnt <= 4'd0;
            end else if (state == READ) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // Address capture, one byte per address cycle. Not reset: it is always
    // rewritten before it is used.
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.start) begin
            addr[23:16] <= bus.address;
        end
        if (state == ADDR_MID) begin
            addr[15:8] <= bus.address;
        end
        if (state == ADDR_LO) begin
            addr[7:0] <= bus.address;
        end
    end

    // In ADDR_LO the low byte is still on the bus, so the index is built
    // from it directly; this lets the read launch on entry to READ.
    always_comb begin
        lo_word = (state == ADDR_LO) ? {addr[15:8], bus.address} : addr[15:0];
        mem_idx = lo_word[MEM_AW-1:0];
    end

    // Synchronous memory: read launched when leaving ADDR_LO so rd_data is
    // stable for the whole READ state; writes complete on dv_in in WRITE.
    // A write coinciding with reset is dropped because reset aborts it.
    always_ff @(posedge clock) begin
        if (state == ADDR_LO) begin
            rd_data <= mem[mem_idx];
        end
        if (!reset && state == WRITE && bus.dv_in) begin
            mem[mem_idx] <= bus.data_in;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (bus.start) next_state = ADDR_MID;
            ADDR_MID: next_state = (addr[23:16] == DEV_ID) ? ADDR_LO : IDLE;
            ADDR_LO:  next_state = bus.read ? READ : WRITE;
            READ:     if (wait_cnt == LAST_CNT) next_state = IDLE;
            WRITE:    if (bus.dv_in) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Bus drive: only READ ever enables a driver, so an unselected follower
    // stays off the bus.
    always_comb begin
        bus.dv_oe    = 1'b0;
        bus.dv_out   = 1'b0;
        bus.data_oe  = 1'b0;
        bus.data_out = 8'h00;
        if (state == READ) begin
            bus.dv_oe = 1'b1;
            if (wait_cnt == LAST_CNT) begin
                bus.dv_out   = 1'b1;
                bus.data_oe  = 1'b1;
                bus.data_out = rd_data;
            end
        end
    end

endmodule

// File: tb/tb_simplebus_mem_follower.sv
// tb_simplebus_mem_follower
// Directed bench for simplebus_mem_follower with DEV_ID=1, MEM_AW=16,
// READ_LATENCY=2. Inputs change 1ns after the rising edge; outputs are
// checked in that same settled window. Expected values are hand-derived.
// With SIMPLEBUS_MEM_INIT_EN defined, an unwritten location must read DEV_ID.
module tb_simplebus_mem_follower;

    localparam logic [7:0] DEV_ID = 8'h01;
    localparam int         RL     = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    simplebus_mem_follower_if bus ();

    simplebus_mem_follower #(
        .DEV_ID       (DEV_ID),
        .MEM_AW       (16),
        .READ_LATENCY (RL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Advance one clock and land in the quiet window after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // No driver enabled on the bus.
    task automatic check_idle(input string tag);
        check_output({tag, " dv_oe"},   {7'b0, bus.dv_oe},   8'h00);
        check_output({tag, " data_oe"}, {7'b0, bus.data_oe}, 8'h00);
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [7:0] a,
                                  input logic dv, input logic [7:0] d);
        bus.start   = s;
        bus.read    = r;
        bus.address = a;
        bus.dv_in   = dv;
        bus.data_in = d;
    endtask

    // Three address cycles; returns with the FSM in READ/WRITE (or IDLE if unselected).
    task automatic send_addr(input logic [23:0] a, input logic r);
        apply_stimulus(1'b1, 1'b0, a[23:16], 1'b0, 8'h00);
        tick();
        apply_stimulus(1'b0, 1'b0, a[15:8], 1'b0, 8'h00);
        tick();
        apply_stimulus(1'b0, r, a[7:0], 1'b0, 8'h00);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic write_txn(input string tag, input logic [23:0] a, input logic [7:0] d);
        send_addr(a, 1'b0);
        check_idle({tag, " in WRITE"});
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, d);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic read_txn(input string tag, input logic [23:0] a, input logic [7:0] exp);
        send_addr(a, 1'b1);
        for (int i = 0; i < RL - 1; i++) begin
            check_output({tag, " wait dv_oe"},   {7'b0, bus.dv_oe},   8'h01);
            check_output({tag, " wait dv_out"},  {7'b0, bus.dv_out},  8'h00);
            check_output({tag, " wait data_oe"}, {7'b0, bus.data_oe}, 8'h00);
            tick();
        end
        check_output({tag, " dv_oe"},    {7'b0, bus.dv_oe},   8'h01);
        check_output({tag, " dv_out"},   {7'b0, bus.dv_out},  8'h01);
        check_output({tag, " data_oe"},  {7'b0, bus.data_oe}, 8'h01);
        check_output({tag, " data_out"}, bus.data_out,        exp);
        tick();
        check_idle({tag, " after"});
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Reset state.
        tick();
        tick();
        check_idle("reset");
        check_output("reset dv_out", {7'b0, bus.dv_out}, 8'h00);
        reset = 1'b0;
        tick();
        check_idle("post reset");

        // Write then read back; back-to-back transactions also show IDLE return.
        write_txn("w1", 24'h010406, 8'hDC);
        read_txn("r1", 24'h010406, 8'hDC);

        // Two locations, then overwrite.
        write_txn("w2", 24'h010407, 8'hAB);
        read_txn("r2a", 24'h010406, 8'hDC);
        read_txn("r2b", 24'h010407, 8'hAB);
        write_txn("w3", 24'h010406, 8'hF1);
        read_txn("r3", 24'h010406, 8'hF1);

        // Unselected device id: goes back to IDLE after the mid byte, never drives.
        apply_stimulus(1'b1, 1'b0, 8'h02, 1'b0, 8'h00);
        tick();
        check_idle("other id mid");
        apply_stimulus(1'b0, 1'b0, 8'h04, 1'b0, 8'h00);
        tick();
        check_idle("other id lo");
        apply_stimulus(1'b0, 1'b1, 8'h06, 1'b1, 8'h77);
        tick();
        check_idle("other id after lo");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        check_idle("other id tail");
        read_txn("r4", 24'h010406, 8'hF1);

        // Long write wait; a stray start during WRITE must be ignored.
        send_addr(24'h010410, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(i == 4, 1'b1, 8'h01, 1'b0, 8'h33);
            check_idle("write wait");
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        read_txn("r5", 24'h010410, 8'h5A);
        read_txn("r5 other", 24'h010406, 8'hF1);

        // Reset in the last READ cycle (counter=1) aborts the read.
        send_addr(24'h010407, 1'b1);
        tick();
        check_output("pre-reset dv_out", {7'b0, bus.dv_out}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset in READ");
        check_output("reset in READ dv_out", {7'b0, bus.dv_out}, 8'h00);
        tick();
        check_idle("reset in READ next");
        read_txn("r6", 24'h010407, 8'hAB);

`ifdef SIMPLEBUS_MEM_INIT_EN
        // Unwritten location holds the power-up value DEV_ID.
        read_txn("init", 24'h011234, DEV_ID);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/simplebus_mem_follower.md
Name: simplebus_mem_follower

Overview:
- Memory follower on the shared 8-bit multiplexed simplebus.
- Captures a 24-bit address sent as three consecutive bytes (upper, mid, low) after a leader start pulse.
- Responds only when the upper address byte equals its DEV_ID; several instances with different IDs share one bus.
- Serves reads from, and writes into, a local 2^MEM_AW x 8 memory indexed by the low MEM_AW address bits.

Parameters:
DEV_ID, 0, 8-bit device select; compared with address byte 2.
MEM_AW, 16, memory address width; must be ≤16; depth 2^MEM_AW.
READ_LATENCY, 2, cycles spent in READ before data is driven; range 1..15.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  leader start strobe, valid in the upper-address cycle
read  input  1  1=read, 0=write; valid in the low-address cycle
address  input  8  multiplexed address byte
data_in  input  8  bus data as seen by the follower
data_out  output  8  read data driven to the bus
data_oe  output  1  tri-state enable for data_out
dv_in  input  1  bus dataValid as seen by the follower
dv_out  output  1  dataValid driven by the follower
dv_oe  output  1  tri-state enable for dv_out

Behaviour:
- Reset (synchronous, reset=1 at a rising edge): state=IDLE, wait counter=0, data_oe=0, dv_oe=0, dv_out=0. Address register and memory are not reset. Reset wins over any in-progress transaction from any state.
- FSM states: IDLE, ADDR_MID, ADDR_LO, READ, WRITE.
- IDLE:
  - start=1 → load address into addr[23:16], go to ADDR_MID.
  - Otherwise stay in IDLE.
- ADDR_MID:
  - Always load address into addr[15:8].
  - addr[23:16]==DEV_ID → ADDR_LO; else → IDLE (transaction ignored, no bus drive).
- ADDR_LO:
  - Load address into addr[7:0].
  - read=1 → READ, clear the counter; read=0 → WRITE.
- READ:
  - dv_oe=1 for the entire state; dv_out=0 while waiting.
  - Counter increments each cycle.
  - In the cycle where counter==READ_LATENCY-1: dv_out=1, data_oe=1, data_out=mem[addr[MEM_AW-1:0]]; next state IDLE.
  - data_oe=0 in every other cycle.
  - Memory read is synchronous, launched on entry to READ, so data is stable before it is driven.
- WRITE:
  - Outputs are never driven.
  - dv_in=1 → mem[addr[MEM_AW-1:0]] <= data_in at that edge, go to IDLE.
  - Otherwise wait in WRITE indefinitely.
- Address bits above MEM_AW, other than byte 2, are ignored; the index aliases/wraps.
- start is ignored in every state except IDLE.
- A new transaction may begin in the cycle immediately after returning to IDLE.
- Minimum transaction lengths:
  - Read: 3 address cycles + READ_LATENCY.
  - Write: 3 address cycles + 1.
- dv_oe and data_oe are never asserted outside READ. A non-selected follower never drives the bus.

Optional Feature:
SIMPLEBUS_MEM_INIT_EN:
- Defined: every memory word powers up / initialises to DEV_ID[7:0]; FPGA init / simulation only, not affected by reset.
- Undefined: memory contents are unspecified until written, and reads of unwritten locations return X/undefined.

Test Plan:
1. DEV_ID=1, write 0x010406=0xDC (start+0x01, 0x04, 0x06 with read=0, then dv_in=1, data_in=0xDC), then read 0x010406 → after READ_LATENCY=2 cycles, one cycle of dv_out=1, data_oe=1, data_out=0xDC; FSM back in IDLE.
2. Writes 0x010406=0xDC and 0x010407=0xAB, then reads of both → 0xDC and 0xAB respectively; overwrite 0x010406=0xF1, read → 0xF1.
3. DEV_ID=1, transaction to 0x020406 → FSM goes IDLE→ADDR_MID→IDLE; data_oe and dv_oe stay 0 throughout; memory unchanged; a subsequent read of 0x010406 is unaffected.
4. In WRITE state, hold dv_in=0 for 10 cycles → FSM remains in WRITE and memory is unchanged; then dv_in=1 with data 0x5A → write completes and FSM returns to IDLE.
5. Assert reset during READ at counter=1 → next state IDLE, dv_oe=0, data_oe=0; a following normal read completes correctly.
6. With SIMPLEBUS_MEM_INIT_EN and DEV_ID=3, read unwritten address 0x031234 → data_out=0x03.
